// File: rtl/sample_deserializer_128.sv
// sample_deserializer_128
// Collects a stream of BITS-wide samples into a frame of 2**SEL_BITS slots
// and presents the whole frame in parallel until the consumer releases it.
//
// Ports
//   CLK          single clock, all state changes on the rising edge
//   RST          synchronous active-high reset (clears state and every slot)
//   in_valid     in_data carries a sample
//   in_data      sample value
//   in_ready     block accepts a sample this cycle (FILL and not in reset)
//   flush        abandon the partial frame (write pointer back to slot 0)
//   frame_ack    consumer releases the held frame
//   wr_index     next slot to be written
//   frame_valid  all slots hold one complete frame (HOLD state)
//   frame_data   slot k at bits [k*BITS +: BITS]
//   frame_count  completed frames, wraps modulo 256
module sample_deserializer_128 #(
  parameter int BITS     = 16,
  parameter int SEL_BITS = 7
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             in_valid,
  input  logic [BITS-1:0]                  in_data,
  output logic                             in_ready,
  input  logic                             flush,
  input  logic                             frame_ack,
  output logic [SEL_BITS-1:0]              wr_index,
  output logic                             frame_valid,
  output logic [(2**SEL_BITS)*BITS-1:0]    frame_data,
  output logic [7:0]                       frame_count
);

  localparam int DEPTH = 2 ** SEL_BITS;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [SEL_BITS-1:0] wr_index_reg;
  logic [SEL_BITS-1:0] wr_index_next;
  logic [7:0]          frame_count_reg;
  logic [7:0]          frame_count_next;
  logic                accept;
  logic                last_slot;

  logic [BITS-1:0]     slot_reg [DEPTH];

  // Ready depends only on state and reset so the source never sees a
  // combinational path from its own in_valid.
  assign in_ready  = (state_reg == FILL) && !RST;

  // flush beats a simultaneous sample.
  assign accept    = in_valid && in_ready && !flush;
  assign last_slot = (wr_index_reg == SEL_BITS'(DEPTH - 1));

  always_comb begin
    state_next       = state_reg;
    wr_index_next    = wr_index_reg;
    frame_count_next = frame_count_reg;
    case (state_reg)
      FILL: begin
        if (flush) begin
          wr_index_next = '0;
        end else if (accept) begin
          // Natural wrap of the pointer returns it to slot 0 on the last write.
          wr_index_next = wr_index_reg + 1'b1;
          if (last_slot) begin
            state_next       = HOLD;
            frame_count_next = frame_count_reg + 8'd1;
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= FILL;
      wr_index_reg    <= '0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wr_index_reg    <= wr_index_next;
      frame_count_reg <= frame_count_next;
    end
  end

  // One register per slot: all slots are visible in parallel and are
  // cleared by reset, so a RAM is not an option here.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge CLK) begin
        if (RST) begin
          slot_reg[gi] <= '0;
        end else if (accept && (wr_index_reg == SEL_BITS'(gi))) begin
          slot_reg[gi] <= in_data;
        end
      end
      assign frame_data[gi*BITS +: BITS] = slot_reg[gi];
    end
  endgenerate

  assign wr_index    = wr_index_reg;
  assign frame_valid = (state_reg == HOLD);
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_sample_deserializer_128.sv
// Self-checking bench for sample_deserializer_128: directed scenarios with
// literal expectations plus a long randomized run, all compared every cycle
// against a frame-level behavioural model.
module tb_sample_deserializer_128;

  localparam int BITS  = 16;
  localparam int SEL   = 7;
  localparam int DEPTH = 128;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  in_valid = 1'b0;
  logic [BITS-1:0]       in_data = '0;
  logic                  in_ready;
  logic                  flush = 1'b0;
  logic                  frame_ack = 1'b0;
  logic [SEL-1:0]        wr_index;
  logic                  frame_valid;
  logic [DEPTH*BITS-1:0] frame_data;
  logic [7:0]            frame_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a plain array of slots, a fill position, a "frame
  // held" flag and a frame counter.
  int m_slot [DEPTH];
  int m_pos;
  bit m_hold;
  int m_count;
  int m_frames;
  bit m_live = 1'b0;

  sample_deserializer_128 #(.BITS(BITS), .SEL_BITS(SEL)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .frame_ack   (frame_ack),
    .wr_index    (wr_index),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BITS-1:0] slot(input int k);
    return frame_data[k*BITS +: BITS];
  endfunction

  // Model reaction to the inputs present at a rising edge.
  task automatic model_edge();
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) m_slot[k] = 0;
      m_pos   = 0;
      m_hold  = 1'b0;
      m_count = 0;
      m_live  = 1'b1;
    end else if (!m_hold) begin
      if (flush) begin
        m_pos = 0;
      end else if (in_valid) begin
        m_slot[m_pos] = int'(in_data);
        m_pos++;
        if (m_pos == DEPTH) begin
          m_pos   = 0;
          m_hold  = 1'b1;
          m_count = (m_count + 1) % 256;
          m_frames++;
        end
      end
    end else if (frame_ack) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic compare_all();
    int bad;
    if (!m_live) return;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_hold && !RST)});
    chk("wr_index", {25'd0, wr_index}, m_pos);
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_hold});
    chk("frame_count", {24'd0, frame_count}, m_count);
    bad = -1;
    for (int k = 0; k < DEPTH; k++) begin
      if (bad < 0 && slot(k) !== BITS'(m_slot[k])) bad = k;
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL frame_data slot %0d: got 0x%0h, expected 0x%0h",
               bad, slot(bad), m_slot[bad]);
    end
  endtask

  // One clock: inputs already set are sampled at the rising edge, the model
  // follows, and outputs are compared at the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    int snap [DEPTH];
    int cyc;

    // Reset
    RST = 1'b1;
    tick();
    tick();
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    RST = 1'b0;
    tick();
    chk("post-rst wr_index", {25'd0, wr_index}, 32'd0);
    chk("post-rst frame_count", {24'd0, frame_count}, 32'd0);
    chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Basic frame 0..127
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = BITS'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("basic frame_valid", {31'd0, frame_valid}, 32'd1);
    chk("basic frame_count", {24'd0, frame_count}, 32'd1);
    chk("basic in_ready", {31'd0, in_ready}, 32'd0);
    chk("basic slot0", {16'd0, slot(0)}, 32'h0000);
    chk("basic slot77", {16'd0, slot(77)}, 32'h004D);
    chk("basic slot127", {16'd0, slot(127)}, 32'h007F);

    // Backpressure in HOLD
    for (int k = 0; k < DEPTH; k++) snap[k] = int'(slot(k));
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    for (int c = 0; c < 10; c++) tick();
    for (int k = 0; k < DEPTH; k += 21)
      chk("hold stable", {16'd0, slot(k)}, snap[k]);
    chk("hold slot5", {16'd0, slot(5)}, 32'h0005);
    in_valid  = 1'b0;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    chk("ack frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("ack in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    chk("resume slot0", {16'd0, slot(0)}, 32'h1234);
    chk("resume wr_index", {25'd0, wr_index}, 32'd1);

    // Flush
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = BITS'(16'hA0 + k);
      tick();
    end
    flush    = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush wr_index", {25'd0, wr_index}, 32'd0);
    for (int k = 0; k < 5; k++)
      chk("flush keep", {16'd0, slot(k)}, 32'hA0 + k);
    chk("flush drop slot5", {16'd0, slot(5)}, 32'h0005);

    // Reset while in HOLD
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = BITS'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("pre-rst hold", {31'd0, frame_valid}, 32'd1);
    RST = 1'b1;
    tick();
    chk("rst-hold in_ready", {31'd0, in_ready}, 32'd0);
    RST = 1'b0;
    chk("rst-hold frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst-hold frame_count", {24'd0, frame_count}, 32'd0);
    chk("rst-hold slot9", {16'd0, slot(9)}, 32'd0);
    chk("rst-hold frame_data", {31'd0, (frame_data == '0)}, 32'd1);

    // Reset at wr_index 60
    for (int k = 0; k < 60; k++) begin
      in_valid = 1'b1;
      in_data  = BITS'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("pre-rst wr_index", {25'd0, wr_index}, 32'd60);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst-mid wr_index", {25'd0, wr_index}, 32'd0);
    chk("rst-mid frame_data", {31'd0, (frame_data == '0)}, 32'd1);
    chk("rst-mid frame_count", {24'd0, frame_count}, 32'd0);

    // 256 gapped frames with frame_ack held high
    m_frames  = 0;
    frame_ack = 1'b1;
    cyc = 0;
    while (m_frames < 256 && cyc < 90000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = BITS'($urandom);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("wrap frames done", m_frames, 32'd256);
    chk("wrap frame_count", {24'd0, frame_count}, 32'd0);
    frame_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
